// File: rtl/writeback_arbiter_if.sv
// Bundle between the execution units, the writeback arbiter and the register unit.
// valid/ready: a unit raises req_i with a stable payload; the transfer happens on
// the clock edge where ack_o[i] is 1, and the payload may change after that edge.
interface writeback_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int REG_W     = 5,
  parameter int DATA_W    = 64
);
  logic                        hold_i;
  logic [NUM_UNITS-1:0]        req_i;
  logic [NUM_UNITS-1:0]        wb1En_i;
  logic [NUM_UNITS-1:0]        wb2En_i;
  logic [NUM_UNITS*REG_W-1:0]  addr1_i;
  logic [NUM_UNITS*REG_W-1:0]  addr2_i;
  logic [NUM_UNITS*DATA_W-1:0] data1_i;
  logic [NUM_UNITS*DATA_W-1:0] data2_i;
  logic [NUM_UNITS-1:0]        is64Bit_i;
  logic [NUM_UNITS-1:0]        ack_o;
  logic                        valid_o;
  logic [2:0]                  functionalUnitCode_o;
  logic                        reg1isWriteback_o;
  logic                        reg2isWriteback_o;
  logic [REG_W-1:0]            reg1WritebackAddress_o;
  logic [REG_W-1:0]            reg2WritebackAddress_o;
  logic [DATA_W-1:0]           reg1WritebackData_o;
  logic [DATA_W-1:0]           reg2WritebackData_o;
  logic                        is64Bit_o;
  logic                        conflict_o;
  logic [2:0]                  ptr_o;

  modport master (
    output hold_i, req_i, wb1En_i, wb2En_i, addr1_i, addr2_i, data1_i, data2_i, is64Bit_i,
    input  ack_o, valid_o, functionalUnitCode_o, reg1isWriteback_o, reg2isWriteback_o,
           reg1WritebackAddress_o, reg2WritebackAddress_o, reg1WritebackData_o,
           reg2WritebackData_o, is64Bit_o, conflict_o, ptr_o
  );

  modport slave (
    input  hold_i, req_i, wb1En_i, wb2En_i, addr1_i, addr2_i, data1_i, data2_i, is64Bit_i,
    output ack_o, valid_o, functionalUnitCode_o, reg1isWriteback_o, reg2isWriteback_o,
           reg1WritebackAddress_o, reg2WritebackAddress_o, reg1WritebackData_o,
           reg2WritebackData_o, is64Bit_o, conflict_o, ptr_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register unit's single writeback port among
// the execution units; the grant is combinational, the payload is registered.
module writeback_arbiter #(
  parameter int         NUM_UNITS = 4,
  parameter int         REG_W     = 5,
  parameter int         DATA_W    = 64,
  parameter logic [2:0] IDLE_CODE = 3'd7
) (
  input logic             clock_i,
  input logic             reset_i,
  writeback_arbiter_if.slave wb
);
  logic [2:0]           ptr_q, ptr_d;
  logic                 valid_q, valid_d;
  logic [2:0]           code_q, code_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic [REG_W-1:0]     a1_q, a1_d;
  logic [REG_W-1:0]     a2_q, a2_d;
  logic [DATA_W-1:0]    d1_q, d1_d;
  logic [DATA_W-1:0]    d2_q, d2_d;
  logic                 m64_q, m64_d;
  logic                 conf_q, conf_d;

  logic                 found;
  int                   g;
  int                   u;
  logic [NUM_UNITS-1:0] ack;
  logic [REG_W-1:0]     sel_a1, sel_a2;
  logic                 sel_e1, sel_e2, clash;

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found = 1'b0;
    g     = 0;
    u     = 0;
    if (!reset_i && !wb.hold_i) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        u = (int'(ptr_q) + k) % NUM_UNITS;
        if (!found && wb.req_i[u]) begin
          found = 1'b1;
          g     = u;
        end
      end
    end
    for (int i = 0; i < NUM_UNITS; i++) ack[i] = found && (g == i);
  end

  assign sel_a1 = wb.addr1_i[g*REG_W +: REG_W];
  assign sel_a2 = wb.addr2_i[g*REG_W +: REG_W];
  assign sel_e1 = wb.wb1En_i[g];
  assign sel_e2 = wb.wb2En_i[g];
  // FX uses slot 2 for CR, which lives in a separate file and cannot clash.
  assign clash  = (g != 0) && sel_e1 && sel_e2 && (sel_a1 == sel_a2);

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    code_d  = IDLE_CODE;
    s1_d    = 1'b0;
    s2_d    = 1'b0;
    conf_d  = 1'b0;
    a1_d    = a1_q;
    a2_d    = a2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    m64_d   = m64_q;
    if (found) begin
      ptr_d   = 3'((g + 1) % NUM_UNITS);
      valid_d = 1'b1;
      code_d  = 3'(g);
      s1_d    = sel_e1;
      s2_d    = sel_e2 && !clash;
      conf_d  = clash;
      a1_d    = sel_a1;
      a2_d    = sel_a2;
      d1_d    = wb.data1_i[g*DATA_W +: DATA_W];
      d2_d    = wb.data2_i[g*DATA_W +: DATA_W];
      m64_d   = wb.is64Bit_i[g];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= IDLE_CODE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      conf_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      m64_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      conf_q  <= conf_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      m64_q   <= m64_d;
    end
  end

  assign wb.ack_o                  = ack;
  assign wb.valid_o                = valid_q;
  assign wb.functionalUnitCode_o   = code_q;
  assign wb.reg1isWriteback_o      = s1_q;
  assign wb.reg2isWriteback_o      = s2_q;
  assign wb.reg1WritebackAddress_o = a1_q;
  assign wb.reg2WritebackAddress_o = a2_q;
  assign wb.reg1WritebackData_o    = d1_q;
  assign wb.reg2WritebackData_o    = d2_q;
  assign wb.is64Bit_o              = m64_q;
  assign wb.conflict_o             = conf_q;
  assign wb.ptr_o                  = ptr_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter against a round-robin
// reference model that tracks the priority pointer and the expected output cycle.
module tb_writeback_arbiter;
  localparam int         N    = 4;
  localparam int         RW   = 5;
  localparam int         DW   = 64;
  localparam logic [2:0] IDLE = 3'd7;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  writeback_arbiter_if #(.NUM_UNITS(N), .REG_W(RW), .DATA_W(DW)) bus();

  writeback_arbiter #(.NUM_UNITS(N), .REG_W(RW), .DATA_W(DW), .IDLE_CODE(IDLE)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wb      (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         m_ptr    = 0;
  logic [2:0] exp_q[$];

  logic          e_valid, e_s1, e_s2, e_conf, e_m64;
  logic [2:0]    e_code;
  logic [RW-1:0] e_a1, e_a2;
  logic [DW-1:0] e_d1, e_d2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_unit(input int u, input bit r, input bit e1, input bit e2,
                          input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2, input bit m64);
    bus.req_i[u]               = r;
    bus.wb1En_i[u]             = e1;
    bus.wb2En_i[u]             = e2;
    bus.addr1_i[u*RW +: RW]    = a1;
    bus.addr2_i[u*RW +: RW]    = a2;
    bus.data1_i[u*DW +: DW]    = d1;
    bus.data2_i[u*DW +: DW]    = d2;
    bus.is64Bit_i[u]           = m64;
  endtask

  task automatic rand_unit(input int u);
    set_unit(u, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_reqs();
    bus.req_i = '0;
  endtask

  // One clock: predict the grant from the current inputs, check ack, then check
  // the registered writeback cycle and pointer after the edge.
  task automatic cycle(input string tag, output int g);
    logic [N-1:0]  ea;
    logic [RW-1:0] a1, a2;
    logic          clash;
    g = -1;
    if (!reset_i && !bus.hold_i)
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.req_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    ea = '0;
    if (g >= 0) ea[g] = 1'b1;
    #1 chk({tag, " ack"}, 64'(bus.ack_o), 64'(ea));
    if (reset_i) begin
      m_ptr = 0; e_valid = 0; e_code = IDLE; e_s1 = 0; e_s2 = 0; e_conf = 0;
      e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0; e_m64 = 0;
    end else if (g >= 0) begin
      a1    = bus.addr1_i[g*RW +: RW];
      a2    = bus.addr2_i[g*RW +: RW];
      clash = (g != 0) && bus.wb1En_i[g] && bus.wb2En_i[g] && (a1 == a2);
      e_valid = 1; e_code = 3'(g); e_s1 = bus.wb1En_i[g];
      e_s2 = bus.wb2En_i[g] && !clash; e_conf = clash;
      e_a1 = a1; e_a2 = a2;
      e_d1 = bus.data1_i[g*DW +: DW]; e_d2 = bus.data2_i[g*DW +: DW];
      e_m64 = bus.is64Bit_i[g];
      m_ptr = (g + 1) % N;
    end else begin
      e_valid = 0; e_code = IDLE; e_s1 = 0; e_s2 = 0; e_conf = 0;
    end
    @(posedge clock_i);
    #1;
    chk({tag, " valid"}, 64'(bus.valid_o), 64'(e_valid));
    chk({tag, " code"},  64'(bus.functionalUnitCode_o), 64'(e_code));
    chk({tag, " s1"},    64'(bus.reg1isWriteback_o), 64'(e_s1));
    chk({tag, " s2"},    64'(bus.reg2isWriteback_o), 64'(e_s2));
    chk({tag, " conf"},  64'(bus.conflict_o), 64'(e_conf));
    chk({tag, " a1"},    64'(bus.reg1WritebackAddress_o), 64'(e_a1));
    chk({tag, " a2"},    64'(bus.reg2WritebackAddress_o), 64'(e_a2));
    chk({tag, " d1"},    bus.reg1WritebackData_o, e_d1);
    chk({tag, " d2"},    bus.reg2WritebackData_o, e_d2);
    chk({tag, " m64"},   64'(bus.is64Bit_o), 64'(e_m64));
    chk({tag, " ptr"},   64'(bus.ptr_o), 64'(m_ptr));
  endtask

  initial begin
    int g;
    bus.hold_i = 1'b0; bus.req_i = '0; bus.wb1En_i = '0; bus.wb2En_i = '0;
    bus.addr1_i = '0; bus.addr2_i = '0; bus.data1_i = '0; bus.data2_i = '0;
    bus.is64Bit_i = '0;

    // Reset with a request present: nothing may be acked.
    set_unit(0, 1, 1, 0, 5'd5, 5'd0, 64'h1234, 64'h0, 0);
    cycle("reset0", g);
    cycle("reset1", g);

    reset_i = 1'b0;
    cycle("fx_single", g);
    chk("fx_single ptr1", 64'(bus.ptr_o), 64'd1);
    chk("fx_single data", bus.reg1WritebackData_o, 64'h1234);
    clear_reqs();
    cycle("idle0", g);

    reset_i = 1'b1;
    cycle("rst_a", g);
    reset_i = 1'b0;
    for (int u = 0; u < N; u++)
      set_unit(u, 1, 1, 1, RW'(u), RW'(u + 8), 64'(u * 16 + 1), 64'(u * 16 + 2), 1'(u));
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i % N));
    for (int i = 0; i < 8; i++) begin
      cycle("all_req", g);
      chk("all_req seq", 64'(bus.functionalUnitCode_o), 64'(exp_q.pop_front()));
    end
    clear_reqs();

    // Move the pointer to 3, then FX must win through the wrap before LdSt.
    bus.req_i[2] = 1'b1;
    cycle("ptr_to3", g);
    clear_reqs();
    bus.req_i[0] = 1'b1;
    bus.req_i[2] = 1'b1;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    cycle("wrap_fx", g);
    chk("wrap seq", 64'(bus.functionalUnitCode_o), 64'(exp_q.pop_front()));
    bus.req_i[0] = 1'b0;
    cycle("wrap_ls", g);
    chk("wrap seq", 64'(bus.functionalUnitCode_o), 64'(exp_q.pop_front()));
    clear_reqs();

    set_unit(2, 1, 1, 1, 5'd3, 5'd4, 64'hAAAA, 64'hBBBB, 1);
    cycle("ls_dual", g);
    chk("ls_dual conf", 64'(bus.conflict_o), 64'd0);
    set_unit(2, 1, 1, 1, 5'd7, 5'd7, 64'hCCCC, 64'hDDDD, 0);
    cycle("ls_clash", g);
    chk("ls_clash conf", 64'(bus.conflict_o), 64'd1);
    clear_reqs();
    cycle("clash_end", g);

    bus.hold_i = 1'b1;
    set_unit(1, 1, 1, 0, 5'd9, 5'd0, 64'h5555, 64'h0, 1);
    for (int i = 0; i < 3; i++) cycle("hold", g);
    bus.hold_i = 1'b0;
    cycle("hold_rel", g);
    chk("hold_rel code", 64'(bus.functionalUnitCode_o), 64'd1);
    clear_reqs();

    set_unit(1, 1, 1, 0, 5'd11, 5'd0, 64'h1111, 64'h0, 0);
    set_unit(3, 1, 1, 1, 5'd12, 5'd13, 64'h3333, 64'h4444, 1);
    cycle("pre_rst", g);
    reset_i = 1'b1;
    cycle("mid_rst", g);
    reset_i = 1'b0;
    cycle("post_rst", g);
    chk("post_rst code", 64'(bus.functionalUnitCode_o), 64'd1);
    clear_reqs();

    set_unit(3, 1, 0, 0, 5'd1, 5'd2, 64'h9, 64'hA, 0);
    cycle("branch", g);
    chk("branch code", 64'(bus.functionalUnitCode_o), 64'd3);
    clear_reqs();
    cycle("idle1", g);

    // Random traffic: units keep their payload until acked, then redraw.
    for (int i = 0; i < 300; i++) begin
      bus.hold_i = ($urandom_range(0, 99) < 10);
      reset_i    = ($urandom_range(0, 99) < 3);
      cycle("rand", g);
      if (g >= 0) begin
        if ($urandom_range(0, 99) < 60) rand_unit(g);
        else bus.req_i[g] = 1'b0;
      end
      for (int u = 0; u < N; u++)
        if (!bus.req_i[u] && u != g && $urandom_range(0, 99) < 30) rand_unit(u);
    end
    reset_i = 1'b0;
    bus.hold_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
